ramp_sequencer: RTL and testbench

Soft-start/soft-stop sequencer for the partial-ramp motor stage. It steps the drive through 30 %, 50 % and 100 % levels on command, holding each level for a selectable dwell counted in prescaler ticks. It ramps back down on stop and latches a fault state that forces all level outputs off. It sits between the operator inputs (start/stop buttons, speed switches) and the level outputs, and uses the 1 Hz prescaler output as a clock enable rather than as a clock.

---
 rtl/ramp_sequencer.sv | 129 ++++++++++++
 tb/tb_ramp_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ramp_sequencer.sv
// Soft-start/soft-stop sequencer: ramps the drive through 30/50/100 % levels.
// Each level is held for a latched dwell counted in prescaler ticks. A latched fault forces every level off.
module ramp_sequencer #(
    parameter int DWELL_FAST = 2,
    parameter int DWELL_NORM = 5,
    parameter int DWELL_SLOW = 10,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       fault_in,
    input  logic       fault_clr,
    input  logic       rapido,
    input  logic       lento,
    output logic       out_30,
    output logic       out_50,
    output logic       out_100,
    output logic [2:0] state,
    output logic       busy,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP30 = 3'd1,
        UP50 = 3'd2,
        RUN  = 3'd3,
        DN50 = 3'd4,
        DN30 = 3'd5,
        FLT  = 3'd6
    } state_t;

    state_t           cur_state;
    state_t           nxt_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] dwell;
    logic [CNT_W-1:0] dwell_sel;
    logic             expiry;

    assign state  = cur_state;
    assign expiry = tick && (cnt == (dwell - CNT_W'(1)));

    // Next-state selection; fault_in outranks stop, stop outranks start and expiry.
    always_comb begin
        nxt_state = cur_state;
        if (lento) begin
            dwell_sel = CNT_W'(DWELL_SLOW);
        end else if (rapido) begin
            dwell_sel = CNT_W'(DWELL_FAST);
        end else begin
            dwell_sel = CNT_W'(DWELL_NORM);
        end

        if (fault_in) begin
            nxt_state = FLT;
        end else begin
            case (cur_state)
                IDLE: begin
                    if (start && !stop) nxt_state = UP30;
                    else                nxt_state = IDLE;
                end
                UP30: begin
                    if (stop)        nxt_state = DN30;
                    else if (expiry) nxt_state = UP50;
                    else             nxt_state = UP30;
                end
                UP50: begin
                    if (stop)        nxt_state = DN50;
                    else if (expiry) nxt_state = RUN;
                    else             nxt_state = UP50;
                end
                RUN: begin
                    if (stop) nxt_state = DN50;
                    else      nxt_state = RUN;
                end
                DN50: begin
                    if (expiry) nxt_state = DN30;
                    else        nxt_state = DN50;
                end
                DN30: begin
                    if (expiry) nxt_state = IDLE;
                    else        nxt_state = DN30;
                end
                FLT: begin
                    if (fault_clr) nxt_state = IDLE;
                    else           nxt_state = FLT;
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    // State, dwell counter, latched dwell and outputs decoded from the next state so they align with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= IDLE;
            cnt       <= '0;
            dwell     <= CNT_W'(DWELL_NORM);
            out_30    <= 1'b0;
            out_50    <= 1'b0;
            out_100   <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            if (nxt_state != cur_state) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= cnt;
            end
            if ((cur_state == IDLE) && (nxt_state == UP30)) begin
                dwell <= dwell_sel;
            end else begin
                dwell <= dwell;
            end
            out_30  <= (nxt_state == UP30) || (nxt_state == DN30);
            out_50  <= (nxt_state == UP50) || (nxt_state == DN50);
            out_100 <= (nxt_state == RUN);
            busy    <= (nxt_state != IDLE) && (nxt_state != FLT);
            fault   <= (nxt_state == FLT);
        end
    end

endmodule

// File: tb/tb_ramp_sequencer.sv
// Bench for ramp_sequencer: directed ramp scenarios plus random stimulus against
// a rule-level reference model of levels, dwell ticks and fault handling.
module tb_ramp_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       fault_in = 1'b0;
    logic       fault_clr = 1'b0;
    logic       rapido = 1'b0;
    logic       lento = 1'b0;
    logic       out_30;
    logic       out_50;
    logic       out_100;
    logic [2:0] state;
    logic       busy;
    logic       fault;

    int errors = 0;
    int checks = 0;

    // Reference model: a phase name, ticks counted in the phase, latched dwell.
    int m_st = 0;
    int m_ticks = 0;
    int m_dwell = 5;

    ramp_sequencer dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
        .fault_in(fault_in), .fault_clr(fault_clr), .rapido(rapido), .lento(lento),
        .out_30(out_30), .out_50(out_50), .out_100(out_100),
        .state(state), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_vec();
        logic [2:0] s;
        s = 3'(m_st);
        return {s, (m_st == 1 || m_st == 5), (m_st == 2 || m_st == 4), (m_st == 3),
                (m_st >= 1 && m_st <= 5), (m_st == 6)};
    endfunction

    // Apply the sequencing rules for one clock using the inputs sampled at that edge.
    task automatic model_clock();
        int  nxt;
        bit  done;
        nxt  = m_st;
        done = tick && (m_ticks + 1 >= m_dwell);
        if (reset) begin
            m_st = 0; m_ticks = 0; m_dwell = 5;
            return;
        end
        if (fault_in)                       nxt = 6;
        else if (m_st == 6)                 nxt = fault_clr ? 0 : 6;
        else if (m_st == 0)                 nxt = (start && !stop) ? 1 : 0;
        else if (stop && m_st inside {1, 2, 3})
            nxt = (m_st == 1) ? 5 : 4;
        else if (done && m_st != 3) begin
            // ramp order: 1 -> 2 -> 3 upward, 4 -> 5 -> 0 downward
            if (m_st == 5) nxt = 0;
            else           nxt = m_st + 1;
        end
        if (m_st == 0 && nxt == 1) m_dwell = lento ? 10 : (rapido ? 2 : 5);
        if (nxt != m_st)   m_ticks = 0;
        else if (tick)     m_ticks++;
        m_st = nxt;
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        check("outputs", {24'd0, state, out_30, out_50, out_100, busy, fault}, {24'd0, model_vec()});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; step();
            tick = 1'b0; step();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; step();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; step();
        start = 1'b0;
    endtask

    initial begin
        int c30;
        int c50;
        reset = 1'b1; step(); step();
        reset = 1'b0;
        check("reset_state", {29'd0, state}, 32'd0);
        check("reset_outs", {27'd0, out_30, out_50, out_100, busy, fault}, 32'd0);

        // Normal ramp with a tick every 10 clocks
        pulse_start();
        c30 = 0; c50 = 0;
        for (int i = 0; i < 140; i++) begin
            tick = ((i % 10) == 9);
            if (tick && state == 3'd1) c30++;
            if (tick && state == 3'd2) c50++;
            step();
        end
        tick = 1'b0;
        check("norm_30_ticks", 32'(c30), 32'd5);
        check("norm_50_ticks", 32'(c50), 32'd5);
        check("norm_run", {29'd0, state}, 32'd3);

        // Fast ramp; switching to lento mid-ramp is ignored
        do_reset();
        rapido = 1'b1; pulse_start();
        rapido = 1'b0; lento = 1'b1;
        ticks(1); check("fast_30", {29'd0, state}, 32'd1);
        ticks(1); check("fast_50", {29'd0, state}, 32'd2);
        ticks(1); check("fast_50b", {29'd0, state}, 32'd2);
        ticks(1); check("fast_run", {29'd0, state}, 32'd3);
        lento = 1'b0;

        // Stop during UP50 after one tick
        do_reset();
        pulse_start();
        ticks(6);
        stop = 1'b1; step(); stop = 1'b0;
        check("stop_dn50", {29'd0, state, out_50}, {28'd0, 3'd4, 1'b1});
        ticks(4); check("stop_dn50_hold", {29'd0, state}, 32'd4);
        ticks(1); check("stop_dn30", {29'd0, state, out_30}, {28'd0, 3'd5, 1'b1});
        ticks(5); check("stop_idle", {27'd0, state, out_30, busy}, 32'd0);

        // Fault in RUN
        do_reset();
        pulse_start();
        ticks(10);
        check("flt_pre_run", {29'd0, state}, 32'd3);
        fault_in = 1'b1; step();
        check("flt_enter", {27'd0, state, out_30, out_50, out_100, fault}, {25'd0, 3'd6, 4'b0001});
        fault_clr = 1'b1; step();
        check("flt_hold", {29'd0, state}, 32'd6);
        fault_in = 1'b0; step(); fault_clr = 1'b0;
        check("flt_clear", {29'd0, state}, 32'd0);

        // Tick coincident with the entry edge does not count
        start = 1'b1; tick = 1'b1; step();
        start = 1'b0; tick = 1'b0;
        check("entry_up30", {29'd0, state}, 32'd1);
        ticks(4); check("entry_hold", {29'd0, state}, 32'd1);
        ticks(1); check("entry_up50", {29'd0, state}, 32'd2);

        // Reset while in DN50
        do_reset();
        pulse_start();
        ticks(10);
        stop = 1'b1; step(); stop = 1'b0;
        check("rst_in_dn50", {29'd0, state}, 32'd4);
        do_reset();
        check("rst_dn50_outs", {27'd0, state, out_30, out_50, out_100, busy, fault}, 32'd0);
        pulse_start();
        check("rst_restart", {29'd0, state}, 32'd1);
        ticks(5); check("rst_restart_50", {29'd0, state}, 32'd2);

        // Random stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(999) < 4);
            tick      = ($urandom_range(99) < 25);
            start     = ($urandom_range(99) < 8);
            stop      = ($urandom_range(99) < 3);
            fault_in  = ($urandom_range(999) < 8);
            fault_clr = ($urandom_range(99) < 10);
            if ($urandom_range(99) < 5) begin
                rapido = 1'($urandom_range(1));
                lento  = 1'($urandom_range(1));
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
